// File: rtl/data_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : data_register_bank
// Description : Eight-entry register file feeding the Data_Register_Module
//               read multiplexer. Accepts single-cycle addressed writes and
//               runs a sequenced bank clear (one register per cycle) during
//               which writes are rejected. A per-register valid bitmap marks
//               registers written since the last reset or clear.
//
// Ports       : clk            - clock, rising-edge
//               rst_n          - asynchronous active-low reset
//               Datain         - write data (WIDTH)
//               Datain_address - write target register (3 bits)
//               Enable_in      - write request
//               Clear_req      - bank-clear request
//               out_000..111   - registered contents of registers 0..7
//               Valid          - bit k set: register k written since clear
//               Busy           - high while the clear sequence runs
//               Write_ack      - one-cycle pulse, write accepted
//               Write_err      - one-cycle pulse, write rejected
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_register_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Datain,
    input  logic [2:0]       Datain_address,
    input  logic             Enable_in,
    input  logic             Clear_req,
    output logic [WIDTH-1:0] out_000,
    output logic [WIDTH-1:0] out_001,
    output logic [WIDTH-1:0] out_010,
    output logic [WIDTH-1:0] out_011,
    output logic [WIDTH-1:0] out_100,
    output logic [WIDTH-1:0] out_101,
    output logic [WIDTH-1:0] out_110,
    output logic [WIDTH-1:0] out_111,
    output logic [7:0]       Valid,
    output logic             Busy,
    output logic             Write_ack,
    output logic             Write_err
);

    localparam logic [2:0] c_LAST_PTR = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [WIDTH-1:0] r_regs [8];
    logic [7:0]       r_valid;
    logic             r_busy;
    logic             r_ack;
    logic             r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_valid <= 8'h00;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= CLEAR_VALUE;
            end
        end else begin
            // Handshake flags are single-cycle pulses by default.
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Clear_req) begin
                        // Clear wins over a coincident write; the write is dropped.
                        r_state <= S_CLEAR;
                        r_ptr   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_err   <= Enable_in;
                    end else if (Enable_in) begin
                        r_regs[Datain_address]  <= Datain;
                        r_valid[Datain_address] <= 1'b1;
                        r_ack                   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // One register per edge; further clear requests are ignored.
                    r_regs[r_ptr]  <= CLEAR_VALUE;
                    r_valid[r_ptr] <= 1'b0;
                    r_ptr          <= r_ptr + 3'd1;
                    r_err          <= Enable_in;
                    if (r_ptr == c_LAST_PTR) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_000   = r_regs[0];
    assign out_001   = r_regs[1];
    assign out_010   = r_regs[2];
    assign out_011   = r_regs[3];
    assign out_100   = r_regs[4];
    assign out_101   = r_regs[5];
    assign out_110   = r_regs[6];
    assign out_111   = r_regs[7];
    assign Valid     = r_valid;
    assign Busy      = r_busy;
    assign Write_ack = r_ack;
    assign Write_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_register_bank
// Description : Scoreboard bench for data_register_bank. Stimulus pushes the
//               expected write response (ack or err, with target cycle) into
//               a queue; a monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_register_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] Datain;
    logic [2:0] Datain_address;
    logic       Enable_in;
    logic       Clear_req;
    logic [7:0] out_000, out_001, out_010, out_011;
    logic [7:0] out_100, out_101, out_110, out_111;
    logic [7:0] Valid;
    logic       Busy;
    logic       Write_ack;
    logic       Write_err;

    logic [7:0] outs [8];
    assign outs[0] = out_000;
    assign outs[1] = out_001;
    assign outs[2] = out_010;
    assign outs[3] = out_011;
    assign outs[4] = out_100;
    assign outs[5] = out_101;
    assign outs[6] = out_110;
    assign outs[7] = out_111;

    data_register_bank #(.WIDTH(8), .CLEAR_VALUE(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Datain        (Datain),
        .Datain_address(Datain_address),
        .Enable_in     (Enable_in),
        .Clear_req     (Clear_req),
        .out_000       (out_000),
        .out_001       (out_001),
        .out_010       (out_010),
        .out_011       (out_011),
        .out_100       (out_100),
        .out_101       (out_101),
        .out_110       (out_110),
        .out_111       (out_111),
        .Valid         (Valid),
        .Busy          (Busy),
        .Write_ack     (Write_ack),
        .Write_err     (Write_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        bit         ok;
        logic [2:0] addr;
        logic [7:0] data;
    } resp_t;

    resp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the head entry names the cycle at which its pulse must appear.
    always @(negedge clk) begin
        resp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_response", 32'd0, 32'd1);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("write_ack", {31'd0, Write_ack}, {31'd0, e.ok});
            chk("write_err", {31'd0, Write_err}, {31'd0, !e.ok});
            if (e.ok) begin
                chk("write_data", {24'd0, outs[e.addr]}, {24'd0, e.data});
                chk("write_valid", {31'd0, Valid[e.addr]}, 32'd1);
            end
        end else begin
            chk("no_stray_pulse", {30'd0, Write_ack, Write_err}, 32'd0);
        end
    end

    // Drive a request for one cycle starting at the current falling edge.
    task automatic req(input logic [2:0] a, input logic [7:0] d, input bit we,
                       input bit clr, input bit expect_ok);
        Datain_address = a;
        Datain         = d;
        Enable_in      = we;
        Clear_req      = clr;
        if (we) sb.push_back('{cyc: cyc + 1, ok: expect_ok, addr: a, data: d});
        @(negedge clk);
        Enable_in = 1'b0;
        Clear_req = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        for (int i = 0; i < 8; i++) chk({tag, "_out"}, {24'd0, outs[i]}, 32'd0);
        chk({tag, "_valid"}, {24'd0, Valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_ack"}, {31'd0, Write_ack}, 32'd0);
        chk({tag, "_err"}, {31'd0, Write_err}, 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        Datain         = 8'h00;
        Datain_address = 3'd0;
        Enable_in      = 1'b0;
        Clear_req      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset("after_reset");

        // Two back-to-back writes.
        req(3'b011, 8'hA5, 1'b1, 1'b0, 1'b1);
        req(3'b111, 8'h3C, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("valid_two_writes", {24'd0, Valid}, 32'h88);
        chk("out_011_hold", {24'd0, out_011}, 32'hA5);

        // Fill the bank, then a one-cycle clear pulse with a write in clear cycle 5.
        for (int i = 0; i < 8; i++) req(3'(i), 8'hFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("valid_full", {24'd0, Valid}, 32'hFF);
        req(3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j <= 8; j++) begin
            logic [7:0] exp_v;
            exp_v = 8'hFF << j;
            chk("clear_busy", {31'd0, Busy}, (j < 8) ? 32'd1 : 32'd0);
            chk("clear_valid", {24'd0, Valid}, {24'd0, exp_v});
            if (j > 0) chk("clear_zeroed", {24'd0, outs[j-1]}, 32'd0);
            if (j < 8) chk("clear_pending", {24'd0, outs[j]}, 32'hFF);
            if (j == 4) begin
                req(3'b010, 8'h55, 1'b1, 1'b0, 1'b0);
            end else if (j < 8) begin
                @(negedge clk);
            end
        end
        chk("out_010_after_err", {24'd0, out_010}, 32'd0);
        req(3'b010, 8'h55, 1'b1, 1'b0, 1'b1);
        chk("out_010_retry", {24'd0, out_010}, 32'h55);

        // Simultaneous clear and write in IDLE: clear wins, write rejected.
        req(3'b101, 8'h9A, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk("simul_busy", {31'd0, Busy}, 32'd1);
            @(negedge clk);
        end
        chk("simul_busy_end", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 8; i++) chk("simul_no_data", {24'd0, outs[i]}, 32'd0);

        // Reset asserted in clear cycle 3 aborts the sequence.
        req(3'b110, 8'h77, 1'b1, 1'b0, 1'b1);
        req(3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("pre_abort_busy", {31'd0, Busy}, 32'd1);
        chk("pre_abort_reg6", {24'd0, out_110}, 32'h77);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_valid", {24'd0, Valid}, 32'd0);
        chk("abort_reg6", {24'd0, out_110}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset("after_abort");
        req(3'b000, 8'h11, 1'b1, 1'b0, 1'b1);
        chk("post_abort_valid", {24'd0, Valid}, 32'h01);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/data_register_bank.md
# data_register_bank

Eight-entry, 8-bit data register file feeding the Data_Register_Module read multiplexer. It holds the eight registers whose contents drive `out_000` … `out_111`, and accepts single-cycle addressed writes. It supports a sequenced bank clear, during which it rejects writes. A per-register valid bitmap tells the control unit which registers have been written since the last reset or clear.

## Interface
Parameters:
- `WIDTH`, 8, data width of each register; all data ports scale with it.
- `CLEAR_VALUE`, 0, value loaded into a register by reset and by the clear sequence.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `Datain` input WIDTH: write data.
- `Datain_address` input 3: write target, 3'b000…3'b111.
- `Enable_in` input 1: write request, sampled each rising edge.
- `Clear_req` input 1: bank-clear request, sampled each rising edge.
- `out_000` … `out_111` output WIDTH each: registered contents of registers 0…7, wired straight to the read mux.
- `Valid` output 8: bit k set means register k was written since the last reset or clear.
- `Busy` output 1: high while the clear sequence runs.
- `Write_ack` output 1: one-cycle pulse confirming an accepted write.
- `Write_err` output 1: one-cycle pulse flagging a rejected write.

## Operation
- The state machine has two states, IDLE and CLEAR. It holds a 3-bit clear pointer `ptr`.
- **Reset** (`rst_n`=0, asynchronous) drives:
  - all registers to CLEAR_VALUE;
  - `Valid`=8'h00, `Busy`=0, `Write_ack`=0, `Write_err`=0;
  - state IDLE, `ptr`=0.
- Reset asserted mid-clear aborts the sequence immediately with the same values.
- **IDLE, `Enable_in`=1, `Clear_req`=0:**
  - register[`Datain_address`] ← `Datain`;
  - `Valid[Datain_address]` ← 1;
  - `Write_ack` ← 1.
  - Other registers are unchanged.
- **IDLE, `Clear_req`=1:**
  - state ← CLEAR, `ptr` ← 0, `Busy` ← 1.
  - If `Enable_in` is also 1, the write is dropped and `Write_err` ← 1. Clear has priority.
- **CLEAR, each edge:**
  - register[`ptr`] ← CLEAR_VALUE;
  - `Valid[ptr]` ← 0;
  - `ptr` ← `ptr`+1.
  - When `ptr`=7: state ← IDLE, `Busy` ← 0, `ptr` wraps to 0.
- **CLEAR, `Enable_in`=1:** the write is dropped and `Write_err` ← 1. There is no queueing.
- **CLEAR, `Clear_req`=1:** ignored; the sequence is neither restarted nor extended.
- `Write_ack` and `Write_err` are high for exactly one cycle per sampled request. Back-to-back accepted writes give back-to-back ack pulses.
- Repeated writes to one address: last write wins, `Valid` bit stays 1.
- Data are stored verbatim, with no arithmetic and no width conversion.

## Timing
- Write latency is 1 cycle. The new value appears on `out_xxx`, and the `Valid` bit rises, right after the edge that samples `Enable_in`=1. `Write_ack` is high during the following cycle.
- The read path is combinational from the registers through the downstream mux. A read of the written address is correct in the cycle after the write edge. There is no same-cycle bypass.
- Clear timing:
  - `Busy` rises after the edge that samples `Clear_req`.
  - Register k reaches CLEAR_VALUE after edge k+1 following the request edge.
  - `Busy` is high for exactly 8 cycles.
- Writes are accepted again on the first edge at which `Busy` is low.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- **Reset values:** release `rst_n` → all `out_xxx`=0, `Valid`=8'h00, `Busy`=0, `Write_ack`=0, `Write_err`=0.
- **Writes:** write 8'hA5 to 3'b011, then 8'h3C to 3'b111 on consecutive cycles →
  - `out_011`=8'hA5 and `out_111`=8'h3C one cycle after their respective write edges;
  - `Valid`=8'h88;
  - two consecutive `Write_ack` pulses.
- **Clear:** fill all 8 registers with 8'hFF, pulse `Clear_req` for 1 cycle →
  - `Busy` high for exactly 8 cycles;
  - `out_000` … `out_111` zeroed in order, one per cycle;
  - `Valid` bits fall 0→7 in order;
  - final `Valid`=8'h00.
- **Write during clear:** `Enable_in`=1 to 3'b010 with 8'h55 in clear cycle 5 → `Write_err` pulse, `Write_ack`=0, `out_010`=0 afterwards. Repeat the write on the first cycle `Busy`=0 → accepted, `out_010`=8'h55.
- **Simultaneous requests in IDLE:** `Clear_req` and `Enable_in` high together in IDLE → `Write_err` pulse, clear runs the full 8 cycles, no register holds the write data.
- **Reset mid-clear:** `rst_n` low in clear cycle 3 → immediate return to reset values, `Busy`=0. A subsequent write of 8'h11 to 3'b000 succeeds with `Write_ack`.
